tpu_host_sequencer: RTL and testbench

TPU_HOST_SEQUENCER -- requirements
Module: tpu_host_sequencer

---
 rtl/tpu_pkg.sv | 17 +
 rtl/tpu_result_buf.sv | 40 ++++
 rtl/tpu_host_sequencer.sv | 138 +++++++++++++
 tb/tb_tpu_host_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU host sequencer: FSM states, header layout, sizes.
package tpu_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_DONE = 3'd2,
        CAPTURE   = 3'd3,
        DRAIN     = 3'd4
    } state_t;

    localparam int HDR_TRANSPOSE_BIT    = 0;
    localparam int HDR_ACTIVATION_BIT   = 1;
    localparam int MATRIX_BYTES         = 8;
    localparam int DEFAULT_RESULT_BYTES = 8;

endpackage

// File: rtl/tpu_result_buf.sv
// Result byte register file with independent write/read pointers and a pointer clear.
// Write lands on the next edge; rd_data is combinational from the read pointer.
module tpu_result_buf #(
    parameter  int DEPTH = 8,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          rd_adv,
    output logic [7:0]    rd_data,
    output logic [PW-1:0] wr_ptr,
    output logic [PW-1:0] rd_ptr
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)  wr_ptr <= wr_ptr + PW'(1);
            if (rd_adv) rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage is deliberately left out of reset; pointers gate what is read.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/tpu_host_sequencer.sv
// Host-side sequencer: header + 8 matrix bytes to the TPU, wait for done, capture and drain results.
// Load bytes reach the TPU one cycle after acceptance; s_ready only in IDLE/LOAD, drain stalls on m_ready.
module tpu_host_sequencer
    import tpu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int RESULT_BYTES   = DEFAULT_RESULT_BYTES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] tpu_data,
    output logic       tpu_load_en,
    output logic       tpu_transpose,
    output logic       tpu_activation,
    input  logic [7:0] tpu_out,
    input  logic       tpu_done,
    output logic       busy,
    output logic       timeout_err
);

    localparam int CW = $clog2(MATRIX_BYTES);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int PW = (RESULT_BYTES > 1) ? $clog2(RESULT_BYTES) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(MATRIX_BYTES - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(RESULT_BYTES - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          hdr_acc, load_acc, buf_wr, tmo_hit, m_xfer;
    logic [7:0]    rd_data;
    logic [PW-1:0] wr_ptr, rd_ptr;

    // Gated by rst_n so the host sees no ready while reset is held.
    assign s_ready = rst_n && ((state == IDLE) || (state == LOAD));
    assign busy    = (state != IDLE);
    assign m_valid = (state == DRAIN);
    assign m_data  = (state == DRAIN) ? rd_data : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hdr_acc   = 1'b0;
        load_acc  = 1'b0;
        buf_wr    = 1'b0;
        tmo_hit   = 1'b0;
        m_xfer    = 1'b0;
        case (state)
            IDLE: begin
                if (s_valid && s_ready) begin
                    hdr_acc   = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                if (s_valid && s_ready) begin
                    load_acc = 1'b1;
                    if (byte_cnt == CNT_LAST) state_nxt = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                // Done is tested first so it wins on the terminal-count cycle.
                if (tpu_done) begin
                    buf_wr    = 1'b1;
                    state_nxt = CAPTURE;
                end else if (tmo_cnt == TMO_LAST) begin
                    tmo_hit   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            CAPTURE: begin
                buf_wr = 1'b1;
                if (wr_ptr == PTR_LAST) state_nxt = DRAIN;
            end
            DRAIN: begin
                if (m_ready) begin
                    m_xfer = 1'b1;
                    if (rd_ptr == PTR_LAST) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt       <= '0;
            tmo_cnt        <= '0;
            tpu_data       <= 8'h00;
            tpu_load_en    <= 1'b0;
            tpu_transpose  <= 1'b0;
            tpu_activation <= 1'b0;
            timeout_err    <= 1'b0;
        end else begin
            tpu_load_en <= load_acc;
            if (hdr_acc) begin
                byte_cnt       <= '0;
                tpu_transpose  <= s_data[HDR_TRANSPOSE_BIT];
                tpu_activation <= s_data[HDR_ACTIVATION_BIT];
                timeout_err    <= 1'b0;
            end
            if (load_acc) begin
                tpu_data <= s_data;
                byte_cnt <= byte_cnt + CW'(1);
            end
            if (load_acc && (byte_cnt == CNT_LAST)) tmo_cnt <= '0;
            else if (state == WAIT_DONE)            tmo_cnt <= tmo_cnt + TW'(1);
            if (tmo_hit) timeout_err <= 1'b1;
        end
    end

    tpu_result_buf #(
        .DEPTH (RESULT_BYTES)
    ) u_result_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (hdr_acc),
        .wr_en   (buf_wr),
        .wr_data (tpu_out),
        .rd_adv  (m_xfer),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

endmodule

// File: tb/tb_tpu_host_sequencer.sv
// Scoreboard bench: stimulus queues expected TPU load bytes and result bytes; a monitor pops and compares.
module tb_tpu_host_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_ready;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready;
    logic [7:0] tpu_data;
    logic       tpu_load_en;
    logic       tpu_transpose;
    logic       tpu_activation;
    logic [7:0] tpu_out;
    logic       tpu_done;
    logic       busy;
    logic       timeout_err;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_load [$];
    logic [7:0] exp_m    [$];
    logic [7:0] last_load = 8'h00;
    logic       stall_mode = 1'b0;
    int         cyc = 0;

    tpu_host_sequencer #(
        .TIMEOUT_CYCLES (20),
        .RESULT_BYTES   (8)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_data         (s_data),
        .s_valid        (s_valid),
        .s_ready        (s_ready),
        .m_data         (m_data),
        .m_valid        (m_valid),
        .m_ready        (m_ready),
        .tpu_data       (tpu_data),
        .tpu_load_en    (tpu_load_en),
        .tpu_transpose  (tpu_transpose),
        .tpu_activation (tpu_activation),
        .tpu_out        (tpu_out),
        .tpu_done       (tpu_done),
        .busy           (busy),
        .timeout_err    (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Host sink: always ready, or a fixed 2-of-3 pattern when stalling.
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            cyc++;
            m_ready = stall_mode ? ((cyc % 3) != 0) : 1'b1;
        end
    end

    // Monitor on the falling edge.
    initial begin
        logic       hold_prev = 1'b0;
        logic [7:0] hold_data = 8'h00;
        forever begin
            @(negedge clk);
            if (tpu_load_en) begin
                if (exp_load.size() == 0) check("load_unexpected", 32'd1, 32'd0);
                else begin
                    last_load = exp_load.pop_front();
                    check("tpu_data", {24'h0, tpu_data}, {24'h0, last_load});
                end
            end else begin
                check("tpu_data_hold", {24'h0, tpu_data}, {24'h0, last_load});
            end
            if (hold_prev && m_valid)
                check("m_data_stall", {24'h0, m_data}, {24'h0, hold_data});
            if (m_valid && m_ready) begin
                if (exp_m.size() == 0) check("m_unexpected", {24'h0, m_data}, 32'hFFFF_FFFF);
                else check("m_data", {24'h0, m_data}, {24'h0, exp_m.pop_front()});
            end
            hold_prev = m_valid && !m_ready;
            hold_data = m_data;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        s_data  = b;
        s_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (s_ready) break;
            n++;
            if (n > 200) begin
                check("s_ready_wait", 32'd0, 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic send_header(input logic [7:0] hdr);
        send_byte(hdr);
        check("tpu_transpose", {31'h0, tpu_transpose}, {31'h0, hdr[0]});
        check("tpu_activation", {31'h0, tpu_activation}, {31'h0, hdr[1]});
        check("timeout_err_clr", {31'h0, timeout_err}, 32'd0);
    endtask

    task automatic load_bytes(input logic [7:0] base, input int count, input bit gap);
        for (int i = 0; i < count; i++) begin
            exp_load.push_back(base + 8'(i));
            send_byte(base + 8'(i));
            if (gap) begin
                s_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        s_valid = 1'b0;
    endtask

    // Called in WAIT_DONE cycle 1; raises done in WAIT_DONE cycle k.
    task automatic run_tpu(input int k, input logic [7:0] base);
        for (int i = 0; i < 8; i++) exp_m.push_back(base + 8'(i));
        repeat (k - 1) begin @(posedge clk); #1; end
        tpu_done = 1'b1;
        tpu_out  = base;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            tpu_done = 1'b0;
            tpu_out  = base + 8'(i);
        end
        @(posedge clk); #1;
        tpu_out = 8'h00;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || exp_m.size() != 0) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain_complete", {31'h0, (n < 2000)}, 32'd1);
        check("load_queue_empty", exp_load.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_s_ready"}, {31'h0, s_ready}, 32'd0);
        check({tag, "_m_valid"}, {31'h0, m_valid}, 32'd0);
        check({tag, "_m_data"}, {24'h0, m_data}, 32'd0);
        check({tag, "_tpu_data"}, {24'h0, tpu_data}, 32'd0);
        check({tag, "_tpu_load_en"}, {31'h0, tpu_load_en}, 32'd0);
        check({tag, "_transpose"}, {31'h0, tpu_transpose}, 32'd0);
        check({tag, "_activation"}, {31'h0, tpu_activation}, 32'd0);
        check({tag, "_busy"}, {31'h0, busy}, 32'd0);
        check({tag, "_timeout_err"}, {31'h0, timeout_err}, 32'd0);
    endtask

    initial begin
        rst_n    = 1'b0;
        s_data   = 8'h00;
        s_valid  = 1'b0;
        tpu_out  = 8'h00;
        tpu_done = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        check_reset_values("rst");
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("s_ready_after_rst", {31'h0, s_ready}, 32'd1);
        check("busy_after_rst", {31'h0, busy}, 32'd0);
        @(posedge clk); #1;

        // Back-to-back load, done in WAIT_DONE cycle 5.
        send_header(8'h03);
        load_bytes(8'h01, 8, 1'b0);
        run_tpu(5, 8'h10);
        wait_idle();

        // Gapped load with host stalls during drain.
        stall_mode = 1'b1;
        send_header(8'h02);
        load_bytes(8'hA1, 8, 1'b1);
        run_tpu(4, 8'h10);
        wait_idle();
        stall_mode = 1'b0;

        // Timeout: done never raised.
        send_header(8'h01);
        load_bytes(8'h21, 8, 1'b0);
        repeat (19) begin @(posedge clk); #1; end
        @(negedge clk);
        check("wait_cycle20_busy", {31'h0, busy}, 32'd1);
        check("wait_cycle20_tmo", {31'h0, timeout_err}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("timeout_err_set", {31'h0, timeout_err}, 32'd1);
        check("timeout_idle", {31'h0, busy}, 32'd0);
        check("timeout_m_valid", {31'h0, m_valid}, 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("timeout_err_sticky", {31'h0, timeout_err}, 32'd1);
        end
        @(posedge clk); #1;

        // Next header clears the flag; done arrives exactly on the terminal count.
        send_header(8'hFC);
        load_bytes(8'h31, 8, 1'b0);
        run_tpu(20, 8'h40);
        wait_idle();
        check("terminal_no_timeout", {31'h0, timeout_err}, 32'd0);

        // Reset in the middle of a load.
        send_header(8'h03);
        load_bytes(8'h61, 4, 1'b0);
        @(posedge clk); #1;
        rst_n     = 1'b0;
        last_load = 8'h00;
        #1;
        check_reset_values("midrst");
        exp_load.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send_header(8'h03);
        load_bytes(8'h51, 8, 1'b0);
        run_tpu(1, 8'hE0);
        wait_idle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
